// File: rtl/ccff_chain_loader_if.sv
// Bus bundle between the chain loader, the bitstream source and the config chain.
interface ccff_chain_loader_if #(
  parameter int unsigned WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_clk_en;
  logic              ccff_tail;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;

  // Loader side
  modport master (
    input  cfg_data, cfg_valid, ccff_tail,
    output cfg_ready, ccff_head, ccff_clk_en, rd_data, rd_valid
  );

  // Bitstream source / chain side
  modport slave (
    output cfg_data, cfg_valid, ccff_tail,
    input  cfg_ready, ccff_head, ccff_clk_en, rd_data, rd_valid
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serial configuration-chain loader: fetches bitstream words, shifts them into
// the chain MSB first, and reads back the bits falling out of the chain tail.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned WORD_W    = 8
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                start,
  ccff_chain_loader_if.master bus,
  output logic                isol_n,
  output logic                busy,
  output logic                done
);

  localparam int unsigned BCNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WCNT_W = $clog2(WORD_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q,     state_nxt;
  logic [WORD_W-1:0] sreg_q,      sreg_nxt;
  logic [BCNT_W-1:0] bcnt_q,      bcnt_nxt;
  logic [WCNT_W-1:0] wcnt_q,      wcnt_nxt;
  logic [WORD_W-1:0] rb_q,        rb_nxt;
  logic [WORD_W-1:0] rd_data_q,   rd_data_nxt;
  logic              rd_valid_q,  rd_valid_nxt;
  logic              isol_n_q,    isol_n_nxt;
  logic              cfg_ready_q, cfg_ready_nxt;
  logic              head_q,      head_nxt;
  logic              clk_en_q,    clk_en_nxt;
  logic              busy_q,      busy_nxt;
  logic              done_q,      done_nxt;

  logic [WORD_W-1:0] rb_capt;
  logic              chain_last;
  logic              word_last;

  // State and registered outputs
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bcnt_q      <= '0;
      wcnt_q      <= '0;
      rb_q        <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      isol_n_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      sreg_q      <= sreg_nxt;
      bcnt_q      <= bcnt_nxt;
      wcnt_q      <= wcnt_nxt;
      rb_q        <= rb_nxt;
      rd_data_q   <= rd_data_nxt;
      rd_valid_q  <= rd_valid_nxt;
      isol_n_q    <= isol_n_nxt;
      cfg_ready_q <= cfg_ready_nxt;
      head_q      <= head_nxt;
      clk_en_q    <= clk_en_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
    end
  end

  // Next-state, datapath and next-output decode
  always_comb begin
    state_nxt    = state_q;
    sreg_nxt     = sreg_q;
    bcnt_nxt     = bcnt_q;
    wcnt_nxt     = wcnt_q;
    rb_nxt       = rb_q;
    rd_data_nxt  = rd_data_q;
    rd_valid_nxt = 1'b0;
    isol_n_nxt   = isol_n_q;
    rb_capt      = {rb_q[WORD_W-2:0], bus.ccff_tail};
    chain_last   = (bcnt_q == BCNT_W'(CHAIN_LEN - 1));
    word_last    = (wcnt_q == WCNT_W'(WORD_W - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt  = FETCH;
          isol_n_nxt = 1'b0;
          bcnt_nxt   = '0;
          wcnt_nxt   = '0;
          rb_nxt     = '0;
        end
      end
      FETCH: begin
        if (bus.cfg_valid && cfg_ready_q) begin
          sreg_nxt  = bus.cfg_data;
          wcnt_nxt  = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sreg_nxt = {sreg_q[WORD_W-2:0], 1'b0};
        bcnt_nxt = bcnt_q + BCNT_W'(1);
        wcnt_nxt = wcnt_q + WCNT_W'(1);
        rb_nxt   = rb_capt;
        // A full word, or the tail end of the chain, is handed out and the
        // readback register restarts empty so a partial word is right-aligned.
        if (word_last || chain_last) begin
          rd_data_nxt  = rb_capt;
          rd_valid_nxt = 1'b1;
          rb_nxt       = '0;
        end
        if (chain_last) begin
          state_nxt  = DONE;
          isol_n_nxt = 1'b1;
        end else if (word_last) begin
          state_nxt = FETCH;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    cfg_ready_nxt = (state_nxt == FETCH);
    clk_en_nxt    = (state_nxt == SHIFT);
    head_nxt      = clk_en_nxt & sreg_nxt[WORD_W-1];
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state_nxt == DONE);
  end

  assign bus.cfg_ready   = cfg_ready_q;
  assign bus.ccff_head   = head_q;
  assign bus.ccff_clk_en = clk_en_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign isol_n          = isol_n_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 20-bit and an 8-bit chain, each with a
// behavioural shift-chain model, checked against a bit-queue reference.
module tb_ccff_chain_loader;

  localparam int unsigned W = 8;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic         prog_reset;
  logic         start;
  logic         sel;
  logic         chain_clr;
  logic [W-1:0] cfg_data;
  logic         cfg_valid;
  logic         start20, start8;
  logic         isol20, busy20, done20, isol8, busy8, done8;
  logic [19:0]  chain20;
  logic [7:0]   chain8;

  ccff_chain_loader_if #(.WORD_W(W)) bus20 ();
  ccff_chain_loader_if #(.WORD_W(W)) bus8 ();

  assign start20         = start & ~sel;
  assign start8          = start & sel;
  assign bus20.cfg_data  = cfg_data;
  assign bus20.cfg_valid = cfg_valid;
  assign bus20.ccff_tail = chain20[19];
  assign bus8.cfg_data   = cfg_data;
  assign bus8.cfg_valid  = cfg_valid;
  assign bus8.ccff_tail  = chain8[7];

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(W)) u_dut20 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start20), .bus(bus20),
    .isol_n(isol20), .busy(busy20), .done(done20)
  );

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(W)) u_dut8 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start8), .bus(bus8),
    .isol_n(isol8), .busy(busy8), .done(done8)
  );

  // Physical chains: shift on every enabled chain clock, never reset
  always @(posedge prog_clk) begin
    if (chain_clr) chain20 <= '0;
    else if (bus20.ccff_clk_en) chain20 <= {chain20[18:0], bus20.ccff_head};
  end

  always @(posedge prog_clk) begin
    if (chain_clr) chain8 <= '0;
    else if (bus8.ccff_clk_en) chain8 <= {chain8[6:0], bus8.ccff_head};
  end

  // Observation of the selected DUT
  logic         o_en, o_head, o_ready, o_rdv, o_isol, o_busy, o_done;
  logic [W-1:0] o_rd;
  always_comb begin
    if (sel) begin
      o_en = bus8.ccff_clk_en; o_head = bus8.ccff_head; o_ready = bus8.cfg_ready;
      o_rdv = bus8.rd_valid; o_rd = bus8.rd_data; o_isol = isol8; o_busy = busy8; o_done = done8;
    end else begin
      o_en = bus20.ccff_clk_en; o_head = bus20.ccff_head; o_ready = bus20.cfg_ready;
      o_rdv = bus20.rd_valid; o_rd = bus20.rd_data; o_isol = isol20; o_busy = busy20; o_done = done20;
    end
  end

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] wq[$];
  bit           ref20[$];
  bit           ref8[$];
  logic [31:0]  head_vec;
  logic [W-1:0] last_rd[$];
  bit           last_aborted;

  task automatic do_reset();
    prog_reset = 1'b1;
    repeat (2) @(posedge prog_clk);
    #1;
    prog_reset = 1'b0;
  endtask

  // One load on the selected DUT; gap = FETCH stall cycles between words,
  // abort_at = reset after that many shifted bits, start_at = spurious start.
  task automatic run_load(input int gap, input int abort_at, input int start_at);
    int n_len, n_shift, nwords, idx, stall, cyc, cnt;
    int done_n, done_cyc, first_en, last_en, overlap, bad_isol, bad_busy, span;
    bit exp_h[$];
    bit rbits[$];
    bit got_h[$];
    bit aborted;
    logic [W-1:0] exp_rd[$];
    logic [W-1:0] got_rd[$];
    logic [W-1:0] acc;
    logic [31:0]  ev, gv;
    logic         isol_done;

    n_len   = sel ? 8 : 20;
    nwords  = (n_len + int'(W) - 1) / int'(W);
    n_shift = (abort_at > 0) ? abort_at : n_len;
    // Reference head stream: words MSB first, cut at the chain length
    foreach (wq[i])
      for (int b = int'(W) - 1; b >= 0; b--)
        if (exp_h.size() < n_len) exp_h.push_back(wq[i][b]);
    // Reference chain: every shifted bit pushes out the oldest one
    for (int k = 0; k < n_shift; k++) begin
      if (sel) begin rbits.push_back(ref8.pop_front());  ref8.push_back(exp_h[k]);  end
      else     begin rbits.push_back(ref20.pop_front()); ref20.push_back(exp_h[k]); end
    end
    acc = '0; cnt = 0;
    for (int k = 0; k < n_shift; k++) begin
      acc = {acc[W-2:0], rbits[k]};
      cnt++;
      if (cnt == int'(W) || (k == n_shift - 1 && abort_at == 0)) begin
        exp_rd.push_back(acc); acc = '0; cnt = 0;
      end
    end

    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    idx = 0; stall = 0; done_n = 0; done_cyc = -1; first_en = -1; last_en = -1;
    overlap = 0; bad_isol = 0; bad_busy = 0; aborted = 0; isol_done = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (o_en) begin
        got_h.push_back(o_head);
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (o_en && o_ready) overlap++;
      if (o_rdv) got_rd.push_back(o_rd);
      if (o_isol && !o_done) bad_isol++;
      if (!o_busy) bad_busy++;
      if (o_done) begin done_n++; done_cyc = cyc; isol_done = o_isol; break; end
      if (abort_at > 0 && got_h.size() == abort_at) prog_reset = 1'b1;
      start = (start_at > 0 && o_en && got_h.size() == start_at);
      if (o_ready && stall > 0) begin
        cfg_valid = 1'b0;
        stall--;
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = (idx < wq.size()) ? wq[idx] : W'($urandom);
      end
      if (cfg_valid && o_ready) begin idx++; stall = gap; end
      @(posedge prog_clk); #1;
      start = 1'b0;
      if (prog_reset) begin prog_reset = 1'b0; aborted = 1; break; end
    end

    gv = '0; ev = '0;
    foreach (got_h[k]) gv = {gv[30:0], got_h[k]};
    foreach (exp_h[k]) ev = {ev[30:0], exp_h[k]};
    head_vec = gv;
    last_rd = got_rd;
    last_aborted = aborted;

    checks++;
    if (done_n !== (aborted ? 0 : 1)) begin
      errors++; $display("FAIL done_count got %0d want %0d (timeout or spurious done)", done_n, aborted ? 0 : 1);
    end
    checks++;
    if (got_h.size() !== n_shift) begin
      errors++; $display("FAIL clk_en_count got %0d want %0d", got_h.size(), n_shift);
    end
    checks++;
    if (gv !== (ev >> (n_len - n_shift))) begin
      errors++; $display("FAIL head_stream got %0h want %0h", gv, ev >> (n_len - n_shift));
    end
    checks++;
    if (got_rd.size() !== exp_rd.size()) begin
      errors++; $display("FAIL rd_count got %0d want %0d", got_rd.size(), exp_rd.size());
    end else begin
      foreach (exp_rd[k]) begin
        checks++;
        if (got_rd[k] !== exp_rd[k]) begin
          errors++; $display("FAIL rd_word%0d got %0h want %0h", k, got_rd[k], exp_rd[k]);
        end
      end
    end
    checks++;
    if (overlap !== 0 || bad_isol !== 0 || bad_busy !== 0) begin
      errors++; $display("FAIL load_flags overlap=%0d isol_early=%0d busy_low=%0d want all 0", overlap, bad_isol, bad_busy);
    end
    if (!aborted) begin
      span = n_len - 1 + (nwords - 1) * (1 + gap);
      checks++;
      if (last_en - first_en !== span) begin
        errors++; $display("FAIL shift_span got %0d want %0d", last_en - first_en, span);
      end
      checks++;
      if (done_cyc !== last_en + 1 || isol_done !== 1'b1) begin
        errors++; $display("FAIL done_timing done_cyc=%0d last_en=%0d isol=%b want %0d,1", done_cyc, last_en, isol_done, last_en + 1);
      end
      checks++;
      if (idx !== nwords) begin
        errors++; $display("FAIL words_consumed got %0d want %0d", idx, nwords);
      end
      // Back in IDLE: single-cycle pulses gone, fabric released, valid ignored
      cfg_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(posedge prog_clk); #1;
        checks++;
        if ({o_busy, o_done, o_rdv, o_ready, o_en, o_isol} !== 6'b000001) begin
          errors++; $display("FAIL idle_after_done got %b want 000001", {o_busy, o_done, o_rdv, o_ready, o_en, o_isol});
        end
      end
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    checks++;
    if ({bus20.cfg_ready, bus20.ccff_head, bus20.ccff_clk_en, bus20.rd_valid, isol20, busy20, done20} !== 7'b0) begin
      errors++; $display("FAIL reset_flags20 got %b want 0", {bus20.cfg_ready, bus20.ccff_head, bus20.ccff_clk_en, bus20.rd_valid, isol20, busy20, done20});
    end
    checks++;
    if (bus20.rd_data !== '0) begin
      errors++; $display("FAIL reset_rd_data got %0h want 0", bus20.rd_data);
    end
    checks++;
    if ({bus8.cfg_ready, bus8.ccff_clk_en, bus8.rd_valid, isol8, busy8, done8} !== 6'b0) begin
      errors++; $display("FAIL reset_flags8 got %b want 0", {bus8.cfg_ready, bus8.ccff_clk_en, bus8.rd_valid, isol8, busy8, done8});
    end
  endtask

  task automatic test_directed();
    sel = 1'b0;
    wq = '{8'hA5, 8'h3C, 8'hF0};
    run_load(0, 0, 0);
    checks++;
    if (head_vec !== 32'h000A53CF) begin
      errors++; $display("FAIL directed_head got %0h want a53cf", head_vec);
    end
  endtask

  task automatic test_readback();
    sel = 1'b0;
    wq = '{8'h5A, 8'hC3, 8'h90};
    run_load(0, 0, 0);
    wq = '{W'($urandom), W'($urandom), W'($urandom)};
    run_load(0, 0, 0);
    checks++;
    if (last_rd.size() !== 3) begin
      errors++; $display("FAIL readback_count got %0d want 3", last_rd.size());
    end else begin
      checks++;
      if ({last_rd[0], last_rd[1], last_rd[2]} !== 24'h5AC309) begin
        errors++; $display("FAIL readback_words got %0h want 5ac309", {last_rd[0], last_rd[1], last_rd[2]});
      end
    end
  endtask

  task automatic test_stall();
    sel = 1'b0;
    wq = '{8'hA5, 8'h3C, 8'hF0};
    run_load(5, 0, 0);
    checks++;
    if (head_vec !== 32'h000A53CF) begin
      errors++; $display("FAIL stall_head got %0h want a53cf", head_vec);
    end
  endtask

  task automatic test_ignore_start();
    sel = 1'b0;
    wq = '{W'($urandom), W'($urandom), W'($urandom)};
    run_load(0, 0, 3);
  endtask

  task automatic test_abort();
    sel = 1'b0;
    wq = '{W'($urandom), W'($urandom), W'($urandom)};
    run_load(0, 10, 0);
    checks++;
    if (last_aborted !== 1'b1) begin
      errors++; $display("FAIL abort_taken got %b want 1", last_aborted);
    end
    checks++;
    if ({bus20.cfg_ready, bus20.ccff_head, bus20.ccff_clk_en, bus20.rd_valid, isol20, busy20, done20} !== 7'b0
        || bus20.rd_data !== '0) begin
      errors++; $display("FAIL abort_outputs got %b/%0h want 0/0",
        {bus20.cfg_ready, bus20.ccff_head, bus20.ccff_clk_en, bus20.rd_valid, isol20, busy20, done20}, bus20.rd_data);
    end
    wq = '{W'($urandom), W'($urandom), W'($urandom)};
    run_load(0, 0, 0);
  endtask

  task automatic test_chain8();
    sel = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wq = '{W'($urandom), W'($urandom)};
      run_load(n, 0, (n == 2) ? 4 : 0);
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    for (int n = 0; n < 5; n++) begin
      wq = '{W'($urandom), W'($urandom), W'($urandom)};
      run_load(int'($urandom_range(0, 3)), 0, 0);
    end
  endtask

  initial begin
    prog_reset = 1'b1;
    start      = 1'b0;
    sel        = 1'b0;
    cfg_valid  = 1'b1;
    cfg_data   = 8'h77;
    chain_clr  = 1'b1;
    for (int k = 0; k < 20; k++) ref20.push_back(1'b0);
    for (int k = 0; k < 8; k++)  ref8.push_back(1'b0);
    @(posedge prog_clk); #1;
    chain_clr = 1'b0;
    test_reset();
    test_directed();
    test_readback();
    test_stall();
    test_ignore_start();
    test_abort();
    test_chain8();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 16, meaning total configuration-chain length in bits (>=1).
REQ-002 Parameter WORD_W, default 8, meaning width of bitstream and readback words (>=2).
REQ-003 prog_clk  input  1  clock; single clock domain, all state on rising edge.
REQ-004 prog_reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 cfg_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
REQ-007 cfg_valid  input  1  cfg_data valid.
REQ-008 cfg_ready  output  1  loader accepts cfg_data this cycle.
REQ-009 ccff_head  output  1  serial bit driven into the chain head.
REQ-010 ccff_clk_en  output  1  chain-clock enable; high exactly on cycles where ccff_head carries a bit to be captured.
REQ-011 ccff_tail  input  1  serial bit returned from the chain tail.
REQ-012 rd_data  output  WORD_W  readback word of bits shifted out of ccff_tail.
REQ-013 rd_valid  output  1  one-cycle strobe, rd_data valid.
REQ-014 isol_n  output  1  fabric isolation; 0 = isolated.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, SHIFT, DONE.
REQ-018 IDLE: start=1 -> FETCH, isol_n<=0 next cycle, bit counter and readback register cleared; otherwise stay.
REQ-019 FETCH: cfg_ready=1; cfg_valid=1 -> load word into shift register, clear word-bit counter, -> SHIFT; cfg_valid=0 -> stay, ccff_clk_en=0.
REQ-020 cfg_ready SHALL be 0 in all states except FETCH; accepted transfer = cfg_valid & cfg_ready.
REQ-021 SHIFT: ccff_clk_en=1, ccff_head = shift-register MSB; each cycle shift left by one, increment bit and word-bit counters.
REQ-022 SHIFT: capture ccff_tail into LSB of readback register (shift left) on every ccff_clk_en cycle.
REQ-023 SHIFT, last chain bit (bit count = CHAIN_LEN-1) -> DONE; remaining bits of current word discarded.
REQ-024 SHIFT, last word bit (word-bit count = WORD_W-1) and not last chain bit -> FETCH (one-cycle bubble minimum, ccff_clk_en=0 while in FETCH).
REQ-025 Last-chain-bit rule SHALL take priority when both REQ-023 and REQ-024 hold.
REQ-026 rd_valid SHALL pulse the cycle after every WORD_W-th captured bit; partial final word, if any, SHALL be emitted on entry to DONE, right-aligned (LSB = last captured bit).
REQ-027 DONE: done=1, isol_n<=1, one cycle, -> IDLE.
REQ-028 start outside IDLE SHALL be ignored; cfg_valid outside FETCH SHALL be ignored with no data consumed.
REQ-029 ccff_clk_en SHALL be 0 in IDLE, FETCH, DONE; exactly CHAIN_LEN enabled cycles per load.
REQ-030 Counters SHALL be clog2(CHAIN_LEN+1) and clog2(WORD_W+1) bits wide; no wrap within one load.

Reset
REQ-031 prog_reset=1 at a clock edge SHALL force IDLE regardless of state, including mid-SHIFT.
REQ-032 Reset values: cfg_ready=0, ccff_head=0, ccff_clk_en=0, rd_data=0, rd_valid=0, isol_n=0, busy=0, done=0; counters and shift registers 0.
REQ-033 A load aborted by reset SHALL not produce done or a partial rd_valid; isol_n stays 0 until a later load completes.

Verification (CHAIN_LEN=20, WORD_W=8)
REQ-034 start, words 0xA5,0x3C,0xF0 with cfg_valid held high -> ccff_head sequence 10100101 00111100 1111, exactly 20 ccff_clk_en cycles, done one cycle after last bit, isol_n 0->1 at done.
REQ-035 Chain preloaded 0x5A,0xC3,0x9 (tail order); second load -> rd_valid three times with rd_data 0x5A, 0xC3, 0x09.
REQ-036 cfg_valid deasserted 5 cycles between words -> ccff_clk_en low throughout the stall, head bit stream identical to REQ-034.
REQ-037 prog_reset asserted after 10 shifted bits -> next cycle all outputs at reset values, no done, isol_n=0; fresh start completes normally.
REQ-038 start pulsed during SHIFT and cfg_valid high in SHIFT/IDLE -> no restart, no extra word consumed; CHAIN_LEN=8 edge case -> exactly one word, no FETCH bubble, done after 8 bits.
